// File: rtl/testframe_pkg.sv
// testframe_pkg: shared FSM encoding, GMII framing and CRC-32 constants
package testframe_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    for (int i = 0; i < 32; i++) reflect32[i] = v[31-i];
  endfunction
endpackage

// File: rtl/testframe_checker_if.sv
// testframe_checker_if: GMII receive bus
interface testframe_checker_if;
  logic [7:0] d;
  logic en;
  logic er;
  modport master(output d, en, er);
  modport slave(input d, en, er);
endinterface

// File: rtl/crc32_gmii.sv
// crc32_gmii: byte-wise reflected CRC-32 register, LSB of each octet first
module crc32_gmii
  import testframe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);
  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);
  logic [31:0] nxt;
  // fold one octet into the running remainder, one bit per iteration
  always_comb begin
    nxt = crc;
    for (int i = 0; i < 8; i++) nxt = (nxt >> 1) ^ ((nxt[0] ^ d[i]) ? POLY_R : 32'h0);
  end
  // remainder register: seeded at frame start, advanced on every data octet
  always_ff @(posedge clk or posedge reset)
    if (reset) crc <= '0;
    else if (init) crc <= CRC_INIT;
    else if (en) crc <= nxt;
endmodule

// File: rtl/testframe_checker.sv
// testframe_checker: GMII receive testframe parser with FCS check, sequence tracking and statistics
module testframe_checker
  import testframe_pkg::*;
#(
  parameter int          PRE_MIN    = 6,
  parameter int          PRE_MAX    = 7,
  parameter int          SIG_OFFSET = 36,
  parameter logic [15:0] SIG_VALUE  = 16'h0007,
  parameter int          SEQ_BYTES  = 8,
  parameter int          SEC_BYTES  = 6,
  parameter int          NSEC_BYTES = 4,
  parameter int          CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  testframe_checker_if.slave      rx,
  input  logic                    clear_stats,
  output logic                    frame_valid,
  output logic                    testframe_match,
  output logic                    fcs_ok,
  output logic                    rx_err,
  output logic                    seq_ok,
  output logic                    seq_gap,
  output logic                    seq_dup,
  output logic [8*SEQ_BYTES-1:0]  sequence_num,
  output logic [8*SEC_BYTES-1:0]  timestamp_sec,
  output logic [8*NSEC_BYTES-1:0] timestamp_nsec,
  output logic [15:0]             frame_len,
  output logic [CNT_W-1:0]        cnt_frames,
  output logic [CNT_W-1:0]        cnt_testframes,
  output logic [CNT_W-1:0]        cnt_fcs_err,
  output logic [CNT_W-1:0]        cnt_gaps,
  output logic [CNT_W-1:0]        cnt_lost
);
  localparam int T = SEQ_BYTES + SEC_BYTES + NSEC_BYTES + 4;
  localparam int SW = 8 * SEQ_BYTES;
  localparam int MIN_LEN = T > SIG_OFFSET + 2 ? T : SIG_OFFSET + 2;
  localparam int PW = $clog2(PRE_MAX + 1) + 1;
  localparam int AW = (CNT_W > SW ? CNT_W : SW) + 1;
  state_t state_q, state_d;
  logic [PW-1:0] pre_cnt;
  logic [8*T-1:0] hist;
  logic [15:0] len_q;
  logic sig_hi, sig_ok, err_q, have_exp;
  logic [SW-1:0] exp_seq, seq, diff;
  logic [31:0] crc;
  logic sfd, end_f, good, match, first, s_ok, s_gap, s_dup;
  logic [AW-1:0] lost_sum;
  logic [CNT_W-1:0] lost_sat;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c, input logic e);
    return c + CNT_W'(e && ~&c);
  endfunction
  crc32_gmii u_crc (
    .clk  (clk),
    .reset(reset),
    .init (sfd),
    .en   (state_q == DATA && rx.en),
    .d    (rx.d),
    .crc  (crc)
  );
  // next-state: preamble length window, SFD, end of frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = rx.en ? (rx.d == PRE_BYTE ? PREAMBLE : DROP) : IDLE;
      PREAMBLE: state_d = !rx.en ? IDLE
                        : rx.d == SFD_BYTE ? (pre_cnt < PW'(PRE_MIN) ? DROP : DATA)
                        : rx.d == PRE_BYTE && pre_cnt < PW'(PRE_MAX) ? PREAMBLE : DROP;
      DATA:     state_d = rx.en ? DATA : IDLE;
      default:  state_d = rx.en ? DROP : IDLE;
    endcase
  end
  // frame verdict and sequence classification, evaluated on the closing cycle
  always_comb begin
    sfd = state_q == PREAMBLE && state_d == DATA;
    end_f = state_q == DATA && !rx.en;
    seq = hist[8*T-1 -: SW];
    diff = seq - exp_seq;
    good = crc == CRC_RESIDUE;
    match = sig_ok && len_q >= 16'(MIN_LEN) && good && !err_q;
    first = !have_exp || clear_stats;
    s_ok = match && (first || seq == exp_seq);
    s_gap = match && !first && seq > exp_seq;
    s_dup = match && !first && seq < exp_seq;
    lost_sum = AW'(cnt_lost) + AW'(diff);
    lost_sat = lost_sum > AW'({CNT_W{1'b1}}) ? '1 : lost_sum[CNT_W-1:0];
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  // preamble counter, trailer history, length, signature and error capture
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre_cnt <= '0;
      hist <= '0;
      len_q <= '0;
      sig_hi <= 1'b0;
      sig_ok <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) pre_cnt <= PW'(1);
      else if (state_q == PREAMBLE && rx.en) pre_cnt <= pre_cnt + 1'b1;
      if (sfd) begin
        hist <= '0;
        len_q <= '0;
        sig_hi <= 1'b0;
        sig_ok <= 1'b0;
        err_q <= 1'b0;
      end else if (state_q == DATA && rx.en) begin
        hist <= {hist[8*T-9:0], rx.d};
        len_q <= len_q + 16'(len_q != 16'hFFFF);
        if (len_q == 16'(SIG_OFFSET)) sig_hi <= rx.d == SIG_VALUE[15:8];
        if (len_q == 16'(SIG_OFFSET + 1)) sig_ok <= sig_hi && rx.d == SIG_VALUE[7:0];
        err_q <= err_q | rx.er;
      end
    end
  // per-frame result registers, loaded on the closing cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      frame_valid <= 1'b0;
      testframe_match <= 1'b0;
      fcs_ok <= 1'b0;
      rx_err <= 1'b0;
      seq_ok <= 1'b0;
      seq_gap <= 1'b0;
      seq_dup <= 1'b0;
      sequence_num <= '0;
      timestamp_sec <= '0;
      timestamp_nsec <= '0;
      frame_len <= '0;
    end else begin
      frame_valid <= end_f;
      if (end_f) begin
        testframe_match <= match;
        fcs_ok <= good;
        rx_err <= err_q;
        seq_ok <= s_ok;
        seq_gap <= s_gap;
        seq_dup <= s_dup;
        sequence_num <= match ? seq : '0;
        timestamp_sec <= match ? hist[8*T-SW-1 -: 8*SEC_BYTES] : '0;
        timestamp_nsec <= match ? hist[32 +: 8*NSEC_BYTES] : '0;
        frame_len <= len_q;
      end
    end
  // statistics and expected sequence; a clear overrides the frame closing with it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_frames <= '0;
      cnt_testframes <= '0;
      cnt_fcs_err <= '0;
      cnt_gaps <= '0;
      cnt_lost <= '0;
      have_exp <= 1'b0;
      exp_seq <= '0;
    end else if (clear_stats) begin
      cnt_frames <= '0;
      cnt_testframes <= '0;
      cnt_fcs_err <= '0;
      cnt_gaps <= '0;
      cnt_lost <= '0;
      have_exp <= end_f && match;
      exp_seq <= end_f && match ? seq + 1'b1 : '0;
    end else if (end_f) begin
      cnt_frames <= inc(cnt_frames, 1'b1);
      cnt_testframes <= inc(cnt_testframes, match);
      cnt_fcs_err <= inc(cnt_fcs_err, !good);
      cnt_gaps <= inc(cnt_gaps, s_gap);
      if (s_gap) cnt_lost <= lost_sat;
      if (match) begin
        have_exp <= 1'b1;
        exp_seq <= seq + 1'b1;
      end
    end
endmodule
